// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, DM first.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    input  logic [2:0]        dm_mode_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_mode_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              anomaly_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_gnt_o,
    output logic [31:0]       perf_dm_gnt_o,
    output logic [31:0]       perf_conflict_o
`endif
);

    // state  | meaning
    // IDLE   | port free, arbitrating (DM before IF)
    // GNT_IF | fetch transfer on the port, waiting for mem_ack_i
    // GNT_DM | data transfer on the port, waiting for mem_ack_i
    // ERR    | bus timeout, port dead until reset
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, ERR} state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt;
    logic            discard_q;
    logic            if_pend, dm_pend, to_hit;
    logic            load_if, load_dm;

    // A requester whose ack pulse is showing still holds req this cycle; don't re-serve it.
    assign if_pend = if_req_i & ~if_ack_o;
    assign dm_pend = dm_req_i & ~dm_ack_o;
    assign to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));

    assign if_stall_o = (state_q == ERR) | if_pend;
    assign dm_stall_o = (state_q == ERR) | dm_pend;

    always_comb begin
        state_d = state_q;
        load_if = 1'b0;
        load_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_pend) begin
                    load_dm = 1'b1;
                    state_d = GNT_DM;
                end else if (if_pend) begin
                    load_if = 1'b1;
                    state_d = GNT_IF;
                end
            end
            GNT_IF: begin
                if (mem_ack_i) begin
                    if (dm_pend) begin
                        load_dm = 1'b1;
                        state_d = GNT_DM;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (to_hit) begin
                    state_d = ERR;
                end
            end
            GNT_DM: begin
                if (mem_ack_i) begin
                    if (if_pend) begin
                        load_if = 1'b1;
                        state_d = GNT_IF;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (to_hit) begin
                    state_d = ERR;
                end
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            to_cnt      <= '0;
            discard_q   <= 1'b0;
            if_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_mode_o  <= 3'b000;
            anomaly_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;

            if (load_dm) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                mem_mode_o  <= dm_mode_i;
                to_cnt      <= '0;
            end else if (load_if) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
                mem_mode_o  <= 3'b010;
                to_cnt      <= '0;
            end else if (state_d == IDLE || state_d == ERR) begin
                mem_req_o <= 1'b0;
            end else if (!mem_ack_i) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // A flush on the ack cycle itself still discards that fetch.
            if (state_q == GNT_IF) begin
                if (mem_ack_i) begin
                    discard_q <= 1'b0;
                    if (!(discard_q | if_flush_i)) begin
                        if_ack_o   <= 1'b1;
                        if_rdata_o <= mem_rdata_i;
                    end
                end else if (if_flush_i) begin
                    discard_q <= 1'b1;
                end
            end

            if (state_q == GNT_DM && mem_ack_i) begin
                dm_ack_o <= 1'b1;
                if (!mem_we_o) begin
                    dm_rdata_o <= mem_rdata_i;
                end
            end

            if (state_d == ERR) begin
                anomaly_o <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_if_gnt_o   <= '0;
            perf_dm_gnt_o   <= '0;
            perf_conflict_o <= '0;
        end else begin
            if (state_q == GNT_IF && mem_ack_i) perf_if_gnt_o <= perf_if_gnt_o + 1'b1;
            if (state_q == GNT_DM && mem_ack_i) perf_dm_gnt_o <= perf_dm_gnt_o + 1'b1;
            if (if_pend && dm_pend) perf_conflict_o <= perf_conflict_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: slave model with programmable wait
// states, per-port expected-data queues popped on each ack pulse.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk_i;
    logic        rst_i;
    logic        if_req_i, if_flush_i, if_ack_o, if_stall_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_ack_o, dm_stall_o;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic [2:0]  dm_mode_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [2:0]  mem_mode_o;
    logic        anomaly_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_mode_i(dm_mode_i), .dm_ack_o(dm_ack_o),
        .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_mode_o(mem_mode_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .anomaly_o(anomaly_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], a[15:0]} ^ 32'h5A5A_A5A5;
    endfunction

    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] model_last;

    // slave model: acks after slave_wait cycles, checks the request stays stable
    bit          slave_on;
    bit          man_ack;
    int          slave_wait;
    int          wcnt;
    logic [31:0] snap_addr, snap_wdata;
    logic        snap_we;
    logic [2:0]  snap_mode;

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        wcnt        = 0;
        forever begin
            @(negedge clk_i);
            #1;
            if (!slave_on) begin
                mem_ack_i = man_ack;
                wcnt      = 0;
            end else begin
                mem_ack_i = 1'b0;
                if (mem_req_o) begin
                    if (wcnt == 0) begin
                        snap_addr  = mem_addr_o;
                        snap_wdata = mem_wdata_o;
                        snap_we    = mem_we_o;
                        snap_mode  = mem_mode_o;
                    end else begin
                        check_eq("mem_addr_stable", mem_addr_o, snap_addr);
                        check_eq("mem_wdata_stable", mem_wdata_o, snap_wdata);
                        check_eq("mem_we_stable", 32'(mem_we_o), 32'(snap_we));
                        check_eq("mem_mode_stable", 32'(mem_mode_o), 32'(snap_mode));
                    end
                    if (wcnt >= slave_wait) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = slave_data(mem_addr_o);
                        wcnt        = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // ack monitor: pops the scoreboards and checks single-cycle pulses
    logic prev_if, prev_dm;
    initial begin
        prev_if = 1'b0;
        prev_dm = 1'b0;
        forever begin
            @(negedge clk_i);
            if (if_ack_o) begin
                check_eq("if_ack_pulse", 32'(prev_if), 0);
                check_eq("if_ack_queued", 32'(if_q.size() > 0), 1);
                if (if_q.size() > 0) check_eq("if_rdata", if_rdata_o, if_q.pop_front());
            end
            if (dm_ack_o) begin
                check_eq("dm_ack_pulse", 32'(prev_dm), 0);
                check_eq("dm_ack_queued", 32'(dm_q.size() > 0), 1);
                if (dm_q.size() > 0) check_eq("dm_rdata", dm_rdata_o, dm_q.pop_front());
            end
            prev_if = if_ack_o;
            prev_dm = dm_ack_o;
        end
    end

    task automatic if_fetch(input logic [31:0] a);
        bit seen;
        if_addr_i = a;
        if_req_i  = 1'b1;
        if_q.push_back(slave_data(a));
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (if_ack_o) seen = 1;
            else check_eq("if_stall_wait", 32'(if_stall_o), 1);
        end
        check_eq("if_ack_seen", 32'(seen), 1);
        if (seen) check_eq("if_stall_at_ack", 32'(if_stall_o), 0);
        if_req_i = 1'b0;
    endtask

    task automatic dm_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] m);
        bit seen;
        dm_we_i    = we;
        dm_addr_i  = a;
        dm_wdata_i = d;
        dm_mode_i  = m;
        dm_req_i   = 1'b1;
        if (!we) model_last = slave_data(a);
        dm_q.push_back(model_last);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (dm_ack_o) seen = 1;
            else check_eq("dm_stall_wait", 32'(dm_stall_o), 1);
        end
        check_eq("dm_ack_seen", 32'(seen), 1);
        if (seen) check_eq("dm_stall_at_ack", 32'(dm_stall_o), 0);
        dm_req_i = 1'b0;
    endtask

    task automatic wait_mem_req(input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk_i);
            if (mem_req_o) seen = 1;
        end
        check_eq(tag, 32'(seen), 1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i      = 1'b0;
        model_last = '0;
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;
        rst_i = 1'b1; if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = 0; dm_wdata_i = 0; dm_mode_i = 0;
        slave_on = 1; man_ack = 0; slave_wait = 0; model_last = 0;
        @(negedge clk_i);
        do_reset();

        // reset state
        check_eq("rst_mem_req", 32'(mem_req_o), 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        check_eq("rst_if_rdata", if_rdata_o, 0);
        check_eq("rst_dm_rdata", dm_rdata_o, 0);
        check_eq("rst_anomaly", 32'(anomaly_o), 0);
        check_eq("rst_stalls", {30'd0, if_stall_o, dm_stall_o}, 0);

        // minimum-latency fetch with zero-wait slave
        if_addr_i = 32'h100;
        if_req_i  = 1'b1;
        if_q.push_back(32'h0000_0013);
        @(negedge clk_i);
        check_eq("lat_mem_req", 32'(mem_req_o), 1);
        check_eq("lat_mem_addr", mem_addr_o, 32'h100);
        check_eq("lat_no_ack_yet", 32'(if_ack_o), 0);
        check_eq("lat_stall", 32'(if_stall_o), 1);
        @(negedge clk_i);
        check_eq("lat_if_ack", 32'(if_ack_o), 1);
        check_eq("lat_if_rdata", if_rdata_o, 32'h0000_0013);
        check_eq("lat_stall_ack", 32'(if_stall_o), 0);
        if_req_i = 1'b0;
        @(negedge clk_i);
        check_eq("lat_no_dup_req", 32'(mem_req_o), 0);

        // simultaneous IF and DM, 2-wait slave; flush during GNT_DM is ignored
        slave_wait = 2;
        fork
            if_fetch(32'h600);
            dm_op(1'b0, 32'h2000, 32'h0, 3'b010);
            begin
                wait_mem_req("prio_grant_seen");
                check_eq("prio_dm_first_addr", mem_addr_o, 32'h2000);
                check_eq("prio_dm_first_we", 32'(mem_we_o), 0);
                if_flush_i = 1'b1;
                @(negedge clk_i);
                if_flush_i = 1'b0;
                seen = 0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    if (dm_ack_o) seen = 1;
                    else @(negedge clk_i);
                end
                check_eq("prio_dm_ack_seen", 32'(seen), 1);
                check_eq("b2b_if_req", 32'(mem_req_o), 1);
                check_eq("b2b_if_addr", mem_addr_o, 32'h600);
            end
        join

        // store: fields presented on the port, load data register untouched
        fork
            dm_op(1'b1, 32'h3000, 32'hDEAD_BEEF, 3'b010);
            begin
                wait_mem_req("st_grant_seen");
                check_eq("st_mem_we", 32'(mem_we_o), 1);
                check_eq("st_mem_addr", mem_addr_o, 32'h3000);
                check_eq("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
                check_eq("st_mem_mode", 32'(mem_mode_o), 2);
            end
        join
        check_eq("st_dm_rdata_held", dm_rdata_o, slave_data(32'h2000));

        // flush during an in-flight fetch: result discarded, re-request serviced
        slave_wait = 3;
        if_addr_i  = 32'h400;
        if_req_i   = 1'b1;
        wait_mem_req("fl_grant_seen");
        check_eq("fl_first_addr", mem_addr_o, 32'h400);
        if_flush_i = 1'b1;
        if_addr_i  = 32'h500;
        if_q.push_back(slave_data(32'h500));
        @(negedge clk_i);
        if_flush_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (if_ack_o) seen = 1;
            else check_eq("fl_stall", 32'(if_stall_o), 1);
        end
        check_eq("fl_ack_seen", 32'(seen), 1);
        if_req_i = 1'b0;

        // mixed concurrent traffic with varied wait states
        for (int i = 0; i < 6; i++) begin
            slave_wait = i % 3;
            fork
                if_fetch(32'h1000 + 32'(i * 4));
                dm_op((i % 2) == 1, 32'h4000 + 32'(i * 8), $urandom(), 3'(i));
            join
        end
        repeat (2) @(negedge clk_i);

        // timeout: slave never acks
        slave_on  = 0;
        man_ack   = 0;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h7000;
        dm_req_i  = 1'b1;
        cnt  = 0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk_i);
            if (anomaly_o) seen = 1;
            else if (mem_req_o) cnt++;
        end
        check_eq("to_anomaly", 32'(anomaly_o), 1);
        check_eq("to_granted_cycles", 32'(cnt), TO);
        check_eq("to_mem_req", 32'(mem_req_o), 0);
        check_eq("to_dm_stall", 32'(dm_stall_o), 1);
        check_eq("to_if_stall", 32'(if_stall_o), 1);
        man_ack = 1;
        repeat (3) begin
            @(negedge clk_i);
            check_eq("err_no_dm_ack", 32'(dm_ack_o), 0);
            check_eq("err_sticky", 32'(anomaly_o), 1);
        end
        man_ack  = 0;
        dm_req_i = 1'b0;
        @(negedge clk_i);
        check_eq("err_stall_forced", {30'd0, if_stall_o, dm_stall_o}, 32'h3);
        do_reset();
        check_eq("to_rst_anomaly", 32'(anomaly_o), 0);
        check_eq("to_rst_mem_req", 32'(mem_req_o), 0);
        check_eq("to_rst_stalls", {30'd0, if_stall_o, dm_stall_o}, 0);

        // reset in the middle of a data transfer, then a late ack
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h8000;
        dm_wdata_i = 32'h1234_5678;
        dm_mode_i  = 3'b001;
        dm_req_i   = 1'b1;
        wait_mem_req("mr_grant_seen");
        @(negedge clk_i);
        rst_i    = 1'b1;
        dm_req_i = 1'b0;
        @(negedge clk_i);
        check_eq("mr_mem_req", 32'(mem_req_o), 0);
        check_eq("mr_mem_we", 32'(mem_we_o), 0);
        check_eq("mr_mem_addr", mem_addr_o, 0);
        check_eq("mr_mem_wdata", mem_wdata_o, 0);
        check_eq("mr_mem_mode", 32'(mem_mode_o), 0);
        check_eq("mr_if_rdata", if_rdata_o, 0);
        check_eq("mr_dm_rdata", dm_rdata_o, 0);
        rst_i   = 1'b0;
        man_ack = 1;
        @(negedge clk_i);
        man_ack = 0;
        repeat (2) begin
            @(negedge clk_i);
            check_eq("mr_late_ack_ignored", 32'(dm_ack_o), 0);
            check_eq("mr_late_mem_req", 32'(mem_req_o), 0);
        end

        check_eq("if_queue_drained", 32'(if_q.size()), 0);
        check_eq("dm_queue_drained", 32'(dm_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
